// File: rtl/scrambler_ctrl.sv
// scrambler_ctrl: LFSR, symbol-count, block-type and DC-balance sequencer for the per-lane TX scrambler
// Ports: TX_CLK clock; rst sync active-low reset; GEN 0=Gen1/2 1=Gen3; sym_valid/back_pressure handshake;
//        sym_data, d_K, sync_header current symbol info; Sc_Data_Out scrambler output for disparity;
//        count symbol index; LFSR_Out_8 / LFSR_Out_8_gen3 keystream bytes; scramblingEnable;
//        LFSR_RST seed-reload pulse; symb_14 / symb_15 DC-balance selects.
// Optional: define SCR_DISABLE_EN to add scr_disable, which blanks scrambling while LFSRs keep sequencing.
module scrambler_ctrl #(
    parameter int                    SEED_WIDTH  = 24,
    parameter int                    COUNT_WIDTH = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [SEED_WIDTH-1:0] LANE_SEED   = 24'h1DBFBC
) (
    input  logic                   TX_CLK,
    input  logic                   rst,
    input  logic                   GEN,
    input  logic                   sym_valid,
    input  logic                   back_pressure,
    input  logic [DATA_WIDTH-1:0]  sym_data,
    input  logic                   d_K,
    input  logic [1:0]             sync_header,
    input  logic [DATA_WIDTH-1:0]  Sc_Data_Out,
`ifdef SCR_DISABLE_EN
    input  logic                   scr_disable,
`endif
    output logic [COUNT_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0]  LFSR_Out_8,
    output logic [DATA_WIDTH-1:0]  LFSR_Out_8_gen3,
    output logic                   scramblingEnable,
    output logic                   LFSR_RST,
    output logic [1:0]             symb_14,
    output logic [1:0]             symb_15
);
    typedef enum logic [2:0] {T_NONE, T_SKP, T_EIE, T_TS1, T_TS2, T_OTH, T_ILL} os_t;
    localparam int              L23   = SEED_WIDTH - 1;
    localparam logic [15:0]     TAP16 = 16'h0039;
    localparam logic [L23-1:0]  TAP23 = 'h210125;

    logic                   r_gen, r_lfsr_rst, r_os;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [15:0]            r_lfsr16;
    logic [L23-1:0]         r_lfsr23;
    logic signed [7:0]      r_disp;
    logic [1:0]             r_symb14, r_symb15;
    os_t                    r_type;

    logic                   w_accept, w_gen_chg, w_cnt0, w_last, w_com, w_skp16, w_os, w_ts, w_dis, w_eie_end;
    os_t                    w_type;
    logic signed [7:0]      w_delta, w_disp_nxt;

    // Galois form: the bit leaving the top of the register is the keystream bit for that serial position
    function automatic logic [15:0] adv16(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int b = 0; b < DATA_WIDTH; b++) t = {t[14:0], 1'b0} ^ (t[15] ? TAP16 : '0);
        return t;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ks16(input logic [15:0] s);
        logic [15:0] t;
        logic [DATA_WIDTH-1:0] k;
        t = s;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            k[b] = t[15];
            t = {t[14:0], 1'b0} ^ (t[15] ? TAP16 : '0);
        end
        return k;
    endfunction

    function automatic logic [L23-1:0] adv23(input logic [L23-1:0] s);
        logic [L23-1:0] t;
        t = s;
        for (int b = 0; b < DATA_WIDTH; b++) t = {t[L23-2:0], 1'b0} ^ (t[L23-1] ? TAP23 : '0);
        return t;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ks23(input logic [L23-1:0] s);
        logic [L23-1:0] t;
        logic [DATA_WIDTH-1:0] k;
        t = s;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            k[b] = t[L23-1];
            t = {t[L23-2:0], 1'b0} ^ (t[L23-1] ? TAP23 : '0);
        end
        return k;
    endfunction

    function automatic logic [1:0] dc_sel(input logic signed [7:0] d, input logic signed [7:0] t);
        return d > t ? 2'b00 : d < -t ? 2'b01 : 2'b10;
    endfunction

`ifdef SCR_DISABLE_EN
    assign w_dis = scr_disable;
`else
    assign w_dis = 1'b0;
`endif

    // Block/OS type is decoded live at symbol 0 so symbol-0 outputs are right in the same cycle
    always_comb begin
        w_accept  = sym_valid & ~back_pressure;
        w_gen_chg = GEN ^ r_gen;
        w_cnt0    = r_count == '0;
        w_last    = &r_count;
        w_com     = d_K && sym_data == 8'hBC;
        w_skp16   = d_K && sym_data == 8'h1C;
        w_os      = w_cnt0 ? sync_header != 2'b01 : r_os;
        w_type    = !w_cnt0 ? r_type :
                    sync_header == 2'b01 ? T_NONE :
                    sync_header != 2'b10 ? T_ILL :
                    sym_data == 8'hAA ? T_SKP :
                    sym_data == 8'h00 ? T_EIE :
                    sym_data == 8'h1E ? T_TS1 :
                    sym_data == 8'h2D ? T_TS2 : T_OTH;
        w_ts      = w_type == T_TS1 || w_type == T_TS2;
        w_eie_end = w_type == T_EIE && w_last;
        w_delta   = '0;
        for (int b = 0; b < DATA_WIDTH; b++) w_delta = w_delta + (Sc_Data_Out[b] ? 8'sd1 : -8'sd1);
        w_disp_nxt = w_cnt0 ? (w_ts ? '0 : r_disp) : (w_ts && !w_last) ? r_disp + w_delta : r_disp;
    end

    assign count            = r_count;
    assign LFSR_Out_8       = w_dis ? '0 : ks16(r_lfsr16);
    assign LFSR_Out_8_gen3  = ks23(r_lfsr23);
    assign scramblingEnable = GEN && !w_dis &&
                              (!w_os || (!w_cnt0 && w_type != T_SKP && w_type != T_EIE && w_type != T_ILL));
    assign LFSR_RST         = r_lfsr_rst;
    assign symb_14          = r_symb14;
    assign symb_15          = r_symb15;

    // DC-balance selects are registered one symbol early so they are stable while symbols 14/15 are presented
    always_ff @(posedge TX_CLK) begin
        r_gen      <= GEN;
        r_lfsr_rst <= 1'b0;
        if (!rst) begin
            r_count  <= '0;
            r_lfsr16 <= '1;
            r_lfsr23 <= LANE_SEED[L23-1:0];
            r_disp   <= '0;
            r_symb14 <= 2'b10;
            r_symb15 <= 2'b10;
            r_os     <= 1'b0;
            r_type   <= T_NONE;
        end else if (w_gen_chg) begin
            r_count    <= '0;
            r_lfsr16   <= '1;
            r_lfsr23   <= LANE_SEED[L23-1:0];
            r_disp     <= '0;
            r_symb14   <= 2'b10;
            r_symb15   <= 2'b10;
            r_lfsr_rst <= 1'b1;
        end else if (w_accept && !GEN) begin
            r_lfsr16   <= w_com ? '1 : w_skp16 ? r_lfsr16 : adv16(r_lfsr16);
            r_lfsr_rst <= w_com;
        end else if (w_accept) begin
            r_count    <= r_count + 1'b1;
            r_os       <= w_os;
            r_type     <= w_type;
            r_disp     <= w_disp_nxt;
            r_lfsr23   <= w_eie_end ? LANE_SEED[L23-1:0] : w_type == T_SKP ? r_lfsr23 : adv23(r_lfsr23);
            r_lfsr_rst <= w_eie_end;
            r_symb14   <= w_ts && r_count == COUNT_WIDTH'(13) ? dc_sel(w_disp_nxt, 8'sd31) : 2'b10;
            r_symb15   <= w_ts && r_count == COUNT_WIDTH'(14) ? dc_sel(w_disp_nxt, 8'sd15) : 2'b10;
        end
    end
endmodule

// File: tb/tb_scrambler_ctrl.sv
// tb_scrambler_ctrl: directed and randomized checks of scrambler_ctrl against a behavioural model
module tb_scrambler_ctrl;
    logic       TX_CLK = 0, rst = 0, GEN = 0, sym_valid = 0, back_pressure = 0, d_K = 0;
    logic [7:0] sym_data = 0, Sc_Data_Out = 0;
    logic [1:0] sync_header = 2'b01;
    logic [3:0] count;
    logic [7:0] LFSR_Out_8, LFSR_Out_8_gen3;
    logic       scramblingEnable, LFSR_RST;
    logic [1:0] symb_14, symb_15;
`ifdef SCR_DISABLE_EN
    logic       scr_disable = 0;
`endif

    scrambler_ctrl dut (
        .TX_CLK(TX_CLK), .rst(rst), .GEN(GEN), .sym_valid(sym_valid), .back_pressure(back_pressure),
        .sym_data(sym_data), .d_K(d_K), .sync_header(sync_header), .Sc_Data_Out(Sc_Data_Out),
`ifdef SCR_DISABLE_EN
        .scr_disable(scr_disable),
`endif
        .count(count), .LFSR_Out_8(LFSR_Out_8), .LFSR_Out_8_gen3(LFSR_Out_8_gen3),
        .scramblingEnable(scramblingEnable), .LFSR_RST(LFSR_RST), .symb_14(symb_14), .symb_15(symb_15)
    );

    always #5 TX_CLK = ~TX_CLK;

    localparam int          T_NONE = 0, T_SKP = 1, T_EIE = 2, T_TS1 = 3, T_TS2 = 4, T_OTH = 5, T_ILL = 6;
    localparam int unsigned SEED = 'h1DBFBC, P16 = 'h10039, P23 = 'hA10125;

    int          n_chk = 0, n_err = 0;
    bit          chk_en = 0;
    int          m_cnt = 0, m_type = T_NONE, m_disp = 0;
    int unsigned m_s16 = 'hFFFF, m_s23 = SEED;
    bit          m_pulse = 0, m_gen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Keystream as multiplication by x modulo the full polynomial; the coefficient pushed past x^(n-1) is the serial bit
    function automatic int unsigned mulx(input int unsigned s, input int n, input int unsigned poly);
        s = s << 1;
        return ((s >> n) & 1) != 0 ? s ^ poly : s;
    endfunction

    function automatic int unsigned adv(input int unsigned s, input int n, input int unsigned poly);
        for (int i = 0; i < 8; i++) s = mulx(s, n, poly);
        return s;
    endfunction

    function automatic logic [7:0] ks(input int unsigned s, input int n, input int unsigned poly);
        logic [7:0] k;
        for (int i = 0; i < 8; i++) begin
            k[i] = ((s >> (n - 1)) & 1) != 0;
            s = mulx(s, n, poly);
        end
        return k;
    endfunction

    function automatic int dec(input logic [1:0] sh, input logic [7:0] d);
        return sh == 2'b01 ? T_NONE : sh != 2'b10 ? T_ILL :
               d == 8'hAA ? T_SKP : d == 8'h00 ? T_EIE : d == 8'h1E ? T_TS1 : d == 8'h2D ? T_TS2 : T_OTH;
    endfunction

    function automatic logic [1:0] dcsel(input int d, input int t);
        return d > t ? 2'b00 : d < -t ? 2'b01 : 2'b10;
    endfunction

    // One clock: compare outputs mid-cycle against the model, then apply the same edge to the model
    task automatic tick;
        int  ty;
        bit  ts;
        @(negedge TX_CLK);
        ty = m_cnt == 0 ? dec(sync_header, sym_data) : m_type;
        ts = ty == T_TS1 || ty == T_TS2;
        if (chk_en) begin
            chk("count", count, m_cnt);
            if (!GEN) chk("ks16", LFSR_Out_8, ks(m_s16, 16, P16));
            else chk("ks23", LFSR_Out_8_gen3, ks(m_s23, 23, P23));
            chk("scr_en", scramblingEnable,
                GEN && (ty == T_NONE || (m_cnt != 0 && ty != T_SKP && ty != T_EIE && ty != T_ILL)));
            chk("lfsr_rst", LFSR_RST, m_pulse);
            chk("symb14", symb_14, (GEN && ts && m_cnt == 14) ? dcsel(m_disp, 31) : 2'b10);
            chk("symb15", symb_15, (GEN && ts && m_cnt == 15) ? dcsel(m_disp, 15) : 2'b10);
        end
        @(posedge TX_CLK);
        m_pulse = 0;
        if (!rst) begin
            m_cnt = 0; m_s16 = 'hFFFF; m_s23 = SEED; m_disp = 0; m_type = T_NONE; m_gen = GEN;
        end else if (GEN != m_gen) begin
            m_gen = GEN; m_cnt = 0; m_s16 = 'hFFFF; m_s23 = SEED; m_disp = 0; m_pulse = 1;
        end else if (sym_valid && !back_pressure && !GEN) begin
            if (d_K && sym_data == 8'hBC) begin
                m_s16 = 'hFFFF;
                m_pulse = 1;
            end else if (!(d_K && sym_data == 8'h1C)) m_s16 = adv(m_s16, 16, P16);
        end else if (sym_valid && !back_pressure) begin
            m_type = ty;
            if (ty == T_EIE && m_cnt == 15) begin
                m_s23 = SEED;
                m_pulse = 1;
            end else if (ty != T_SKP) m_s23 = adv(m_s23, 23, P23);
            if (ts && m_cnt == 0) m_disp = 0;
            else if (ts && m_cnt < 15) m_disp += 2 * $countones(Sc_Data_Out) - 8;
            m_cnt = (m_cnt + 1) % 16;
        end
        #1;
    endtask

    task automatic sym(input logic v, input logic [7:0] d, input logic k, input logic [1:0] sh, input logic [7:0] sd);
        sym_valid = v; sym_data = d; d_K = k; sync_header = sh; Sc_Data_Out = sd; back_pressure = 0;
        tick();
    endtask

    logic [7:0] t1 [4] = '{8'hFF, 8'h17, 8'hC0, 8'h14};
    logic [7:0] k0;
    logic [3:0] c0;
    int         bias;

    initial begin
        rst = 0;
        repeat (2) tick();
        rst = 1;
        chk_en = 1;
        chk("rst_count", count, 0);
        chk("rst_pulse", LFSR_RST, 0);
        chk("rst_ks16", LFSR_Out_8, 8'hFF);
        chk("rst_symb", {symb_14, symb_15}, 4'b1010);

        sym(1, 8'hBC, 1, 2'b01, 0);
        chk("t1_com_pulse", LFSR_RST, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_ks", LFSR_Out_8, t1[i]);
            sym(1, 8'h00, 0, 2'b01, 0);
        end
        chk("t1_pulse_gone", LFSR_RST, 0);

        sym(1, 8'hBC, 1, 2'b01, 0);
        chk("t2_ks0", LFSR_Out_8, 8'hFF);
        sym(1, 8'h00, 0, 2'b01, 0);
        chk("t2_ks1", LFSR_Out_8, 8'h17);
        sym(1, 8'h1C, 1, 2'b01, 0);
        chk("t2_ks_skp", LFSR_Out_8, 8'h17);
        sym(1, 8'h00, 0, 2'b01, 0);

        GEN = 1;
        sym(0, 0, 0, 2'b01, 0);
        chk("t3_gen_pulse", LFSR_RST, 1);
        chk("t3_gen_ks23", LFSR_Out_8_gen3, ks(SEED, 23, P23));
        sym(0, 0, 0, 2'b01, 0);
        for (int i = 0; i < 32; i++) begin
            sym_valid = 1; sym_data = 8'($urandom); d_K = 0; sync_header = 2'b01;
            #1;
            chk("t3_cnt", count, i % 16);
            chk("t3_scr_en", scramblingEnable, 1);
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            sym_valid = 1; sym_data = i == 0 ? 8'hAA : 8'($urandom); sync_header = 2'b10;
            #1;
            if (i == 0) k0 = LFSR_Out_8_gen3;
            chk("t4_ks_hold", LFSR_Out_8_gen3, k0);
            chk("t4_scr_en", scramblingEnable, 0);
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                c0 = count; k0 = LFSR_Out_8_gen3;
                back_pressure = 1;
                repeat (3) begin
                    tick();
                    chk("t5_bp_cnt", count, 4'd7);
                    chk("t5_bp_ks", LFSR_Out_8_gen3, k0);
                end
                chk("t5_cnt_seen", c0, 4'd7);
            end
            sym(1, 8'($urandom), 0, 2'b01, 0);
        end
        chk("t5_wrap", count, 0);

        for (int i = 0; i < 16; i++) begin
            sym_valid = 1; sym_data = i == 0 ? 8'h1E : 8'h4A; sync_header = 2'b10;
            Sc_Data_Out = (i >= 1 && i <= 13) ? 8'hFF : 8'h00;
            #1;
            if (i == 14) chk("t6_symb14", symb_14, 2'b00);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            sym_valid = 1; sym_data = i == 0 ? 8'h00 : (i[0] ? 8'hFF : 8'h00); sync_header = 2'b10;
            #1;
            chk("t6_eie_scr_en", scramblingEnable, 0);
            tick();
        end
        chk("t6_eie_pulse", LFSR_RST, 1);
        chk("t6_eie_seed", LFSR_Out_8_gen3, ks(SEED, 23, P23));

        bias = 0;
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(199) != 0;
            if ($urandom_range(249) == 0) GEN = ~GEN;
            sym_valid = $urandom_range(9) != 0;
            back_pressure = $urandom_range(4) == 0;
            if (!GEN) begin
                case ($urandom_range(4))
                    0: begin sym_data = 8'hBC; d_K = 1; end
                    1: begin sym_data = 8'h1C; d_K = 1; end
                    default: begin sym_data = 8'($urandom); d_K = $urandom_range(7) == 0; end
                endcase
            end else begin
                d_K = 0;
                sync_header = 2'($urandom);
                sym_data = 8'($urandom);
                if (m_cnt == 0) begin
                    bias = $urandom_range(2);
                    sync_header = $urandom_range(9) == 0 ? 2'($urandom) : $urandom_range(2) == 0 ? 2'b01 : 2'b10;
                    case ($urandom_range(5))
                        0: sym_data = 8'hAA;
                        1: sym_data = 8'h00;
                        2: sym_data = 8'h1E;
                        3: sym_data = 8'h2D;
                        default: ;
                    endcase
                end
            end
            Sc_Data_Out = bias == 0 ? 8'hFF : bias == 1 ? 8'h00 : 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
